reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; resetn input 1, asynchronous active-low reset.
REQ-002 SHALL provide the following ID-stage ports:
- id_valid input 1: the ID instruction is valid.
- id_src1 / id_src2 input 5 each: source register numbers.
- id_src1_used / id_src2_used input 1 each: the corresponding source is actually read.
- id_dest input 5: destination register number.
- id_dest_we input 1: the instruction writes id_dest.
REQ-003 SHALL provide the following handshake, writeback and status ports:
- ex_allowin input 1: EX can accept an instruction.
- id_ready output 1: no hazard; ID may issue.
- issue_fire output 1: equals id_valid & id_ready & ex_allowin.
- wb_valid input 1, wb_we input 1, wb_dest input 5: regfile write commits this cycle.
- flush input 1: pipeline flush.
- busy_vec output 32: bit i is 1 when reg i has a pending write.
- stall_cnt output 32: count of hazard-stall cycles.
- sb_err output 1: sticky underflow flag.

Function
REQ-004 SHALL keep a 2-bit pending counter cnt[i] for each register i = 1..31; cnt[0] SHALL be constant 0.
REQ-005 SHALL drive busy_vec[i] = (cnt[i] != 0), with busy_vec[0] = 0 always.
REQ-006 SHALL compute hazard from the current-cycle cnt only; there is no same-cycle writeback bypass, because the regfile write lands at the clock edge.
REQ-007 SHALL assert hazard when any of the following holds:
- id_src1_used and busy_vec[id_src1];
- id_src2_used and busy_vec[id_src2];
- id_dest_we and cnt[id_dest] == 3 (saturation/WAW stall).
REQ-008 SHALL drive id_ready = ~hazard, combinationally.
REQ-009 SHALL mark an issue as counted when issue_fire = 1, id_dest_we = 1 and id_dest != 0; a counted issue increments cnt[id_dest] at the clock edge.
REQ-010 SHALL mark a writeback as counted when wb_valid = 1, wb_we = 1 and wb_dest != 0; a counted writeback decrements cnt[wb_dest] at the clock edge.
REQ-011 SHALL leave the counter unchanged when a counted issue and a counted writeback target the same register in the same cycle.
REQ-012 SHALL hold cnt[wb_dest] at 0 on a counted writeback to a counter already at 0, and SHALL set sb_err to 1 in the next cycle.
REQ-013 SHALL, once sb_err is set, hold it at 1 until reset.
REQ-014 SHALL clear all cnt to 0 on flush = 1 at the next edge, overriding any issue and writeback that cycle.
REQ-015 SHALL force issue_fire to 0 while flush = 1.
REQ-016 SHALL increment stall_cnt by 1 in each cycle where id_valid = 1, hazard = 1 and flush = 0.
REQ-017 SHALL let stall_cnt wrap from 0xFFFFFFFF to 0.
REQ-018 SHALL have no internal latency on id_ready and issue_fire; busy_vec and cnt reflect an event in the cycle after it.
REQ-019 SHALL ignore a writeback to reg 0, and an issue to reg 0 SHALL never stall on WAW.

Reset
REQ-020 SHALL, on resetn = 0, asynchronously set every cnt to 0, busy_vec = 0, stall_cnt = 0 and sb_err = 0.
REQ-021 SHALL, during reset, drive id_ready = 1 and issue_fire = id_valid & ex_allowin & ~flush.
REQ-022 SHALL discard all pending state when reset is asserted mid-operation, with no writeback replay required.
REQ-023 SHALL resume counting on the first rising edge after resetn deasserts.

Verification
REQ-024 Basic RAW stall:
- Stimulus: issue dest = 5 (ex_allowin = 1); next cycle id_src1 = 5, used = 1.
- Required: id_ready = 0 and stall_cnt increments each cycle.
- Then: after wb_dest = 5 commits, id_ready = 1 on the following cycle, not the same one.
REQ-025 Simultaneous issue and writeback:
- Stimulus: cnt[7] = 1; issue dest = 7 and writeback wb_dest = 7 in the same cycle.
- Required: cnt[7] stays 1 and busy_vec[7] = 1.
REQ-026 WAW saturation:
- Stimulus: three issues to dest = 9 with no writeback.
- Required: cnt[9] = 3; a fourth issue to 9 sees id_ready = 0 with src unused.
- Then: one writeback to 9 lets it issue.
REQ-027 Reg 0 and underflow:
- Stimulus: issue dest = 0, then src1 = 0 used.
- Required: no stall and busy_vec = 0.
- Stimulus: writeback to reg 3 with cnt[3] = 0.
- Required: sb_err = 1 next cycle, still 1 ten cycles later.
REQ-028 Flush with concurrent traffic:
- Stimulus: regs 2, 4 and 6 busy; assert flush together with an issue to 8 and a writeback to 2.
- Required: busy_vec = 0 next cycle and issue_fire = 0 during the flush cycle.
REQ-029 Reset mid-stream:
- Stimulus: regs busy and stall_cnt = 12; pulse resetn low between clock edges.
- Required: busy_vec = 0, stall_cnt = 0 and sb_err = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that
// detect RAW/WAW hazards at ID and count stall cycles.
module reg_scoreboard (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_src1_used,
    input  logic        id_src2_used,
    input  logic [4:0]  id_dest,
    input  logic        id_dest_we,
    input  logic        ex_allowin,
    output logic        id_ready,
    output logic        issue_fire,
    input  logic        wb_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    input  logic        flush,
    output logic [31:0] busy_vec,
    output logic [31:0] stall_cnt,
    output logic        sb_err
);

    logic [1:0]  cnt [1:31];
    logic [1:0]  dest_cnt;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;
    logic        hazard;
    logic        iss_cnt;
    logic        wb_cnt;
    logic        wb_pair;

    always_comb begin
        busy_vec = '0;
        dest_cnt = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = (cnt[i] != 2'd0);
            if (id_dest == 5'(i)) dest_cnt = cnt[i];
        end
    end

    assign hazard = (id_src1_used & busy_vec[id_src1])
                  | (id_src2_used & busy_vec[id_src2])
                  | (id_dest_we & (dest_cnt == 2'd3));

    assign id_ready   = ~hazard;
    assign issue_fire = id_valid & id_ready & ex_allowin & ~flush;

    assign iss_cnt = issue_fire & id_dest_we & (id_dest != 5'd0);
    assign wb_cnt  = wb_valid & wb_we & (wb_dest != 5'd0);
    assign wb_pair = iss_cnt & wb_cnt & (id_dest == wb_dest);

    assign inc_vec = iss_cnt ? (32'd1 << id_dest) : 32'd0;
    assign dec_vec = wb_cnt ? (32'd1 << wb_dest) : 32'd0;

    // Matching issue and writeback on one register cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < 32; i++) cnt[i] <= 2'd0;
        end else if (flush) begin
            for (int i = 1; i < 32; i++) cnt[i] <= 2'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + 2'd1;
                else if (dec_vec[i] && !inc_vec[i] && cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err    <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            if (wb_cnt && !flush && !wb_pair && !busy_vec[wb_dest])
                sb_err <= 1'b1;
            if (id_valid && hazard && !flush)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed scenarios plus random traffic
// checked against a per-register pending-count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_src1_used;
    logic        id_src2_used;
    logic [4:0]  id_dest;
    logic        id_dest_we;
    logic        ex_allowin;
    logic        id_ready;
    logic        issue_fire;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic        flush;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;
    logic        sb_err;

    int          mcnt [32];
    logic [31:0] mstall;
    logic        merr;
    int          ntot = 0;
    int          npass = 0;

    reg_scoreboard dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_used (id_src1_used),
        .id_src2_used (id_src2_used),
        .id_dest      (id_dest),
        .id_dest_we   (id_dest_we),
        .ex_allowin   (ex_allowin),
        .id_ready     (id_ready),
        .issue_fire   (issue_fire),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_dest      (wb_dest),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .stall_cnt    (stall_cnt),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        mstall = 32'd0;
        merr   = 1'b0;
    endfunction

    function automatic bit m_hazard();
        bit h;
        h = 1'b0;
        if (id_src1_used && mcnt[id_src1] > 0) h = 1'b1;
        if (id_src2_used && mcnt[id_src2] > 0) h = 1'b1;
        if (id_dest_we && mcnt[id_dest] == 3) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_fire();
        return id_valid && !m_hazard() && ex_allowin && !flush;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) b[i] = (mcnt[i] > 0);
        return b;
    endfunction

    task automatic idle();
        id_valid = 0; id_src1 = 0; id_src2 = 0;
        id_src1_used = 0; id_src2_used = 0;
        id_dest = 0; id_dest_we = 0; ex_allowin = 1;
        wb_valid = 0; wb_we = 0; wb_dest = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] d);
        idle();
        id_valid = 1; id_dest = d; id_dest_we = 1;
    endtask

    task automatic tick();
        bit h, f, iss, wbc;
        @(posedge clk);
        if (!resetn) begin
            m_clear();
        end else begin
            h = m_hazard();
            f = m_fire();
            if (id_valid && h && !flush) mstall = mstall + 32'd1;
            if (flush) begin
                for (int i = 0; i < 32; i++) mcnt[i] = 0;
            end else begin
                iss = f && id_dest_we && id_dest != 0;
                wbc = wb_valid && wb_we && wb_dest != 0;
                if (iss) mcnt[id_dest]++;
                if (wbc) begin
                    if (mcnt[wb_dest] > 0) mcnt[wb_dest]--;
                    else merr = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1;
        idle();
        #1 resetn = 0;
        id_valid = 1; id_src1 = 5; id_src1_used = 1;
        #1;
        m_clear();
        ntot++; if (id_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", id_ready); else npass++;
        ntot++; if (issue_fire !== 1'b1) $display("FAIL rst_fire got=%b exp=1", issue_fire); else npass++;
        ntot++; if (busy_vec !== 32'd0) $display("FAIL rst_busy got=%h exp=0", busy_vec); else npass++;
        ntot++; if (stall_cnt !== 32'd0) $display("FAIL rst_stall got=%0d exp=0", stall_cnt); else npass++;
        ntot++; if (sb_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", sb_err); else npass++;
        flush = 1;
        #1;
        ntot++; if (issue_fire !== 1'b0) $display("FAIL rst_flush_fire got=%b exp=0", issue_fire); else npass++;
        tick();
        tick();
        @(negedge clk);
        resetn = 1;
        idle();
        tick();
        ntot++; if (busy_vec !== 32'd0) $display("FAIL rst_after_busy got=%h exp=0", busy_vec); else npass++;
    endtask

    task automatic test_reg0_underflow();
        issue(0);
        #1;
        ntot++; if (issue_fire !== 1'b1) $display("FAIL r0_fire got=%b exp=1", issue_fire); else npass++;
        tick();
        ntot++; if (busy_vec !== 32'd0) $display("FAIL r0_busy got=%h exp=0", busy_vec); else npass++;
        idle();
        id_valid = 1; id_src1 = 0; id_src1_used = 1;
        id_dest = 0; id_dest_we = 1;
        #1;
        ntot++; if (id_ready !== 1'b1) $display("FAIL r0_src_ready got=%b exp=1", id_ready); else npass++;
        tick();
        idle();
        wb_valid = 1; wb_we = 1; wb_dest = 0;
        tick();
        ntot++; if (sb_err !== 1'b0) $display("FAIL r0_wb_err got=%b exp=0", sb_err); else npass++;
        wb_dest = 3;
        tick();
        idle();
        #1;
        ntot++; if (sb_err !== 1'b1) $display("FAIL uflow_err got=%b exp=1", sb_err); else npass++;
        ntot++; if (busy_vec !== 32'd0) $display("FAIL uflow_busy got=%h exp=0", busy_vec); else npass++;
        repeat (10) tick();
        ntot++; if (sb_err !== 1'b1) $display("FAIL uflow_sticky got=%b exp=1", sb_err); else npass++;
    endtask

    task automatic test_reset_mid();
        issue(10); tick();
        issue(11); tick();
        idle();
        id_valid = 1; id_src2 = 11; id_src2_used = 1;
        repeat (12) tick();
        ntot++; if (stall_cnt !== 32'd12) $display("FAIL mid_stall12 got=%0d exp=12", stall_cnt); else npass++;
        ntot++; if (busy_vec !== 32'h0000_0C00) $display("FAIL mid_busy_pre got=%h exp=00000c00", busy_vec); else npass++;
        #2 resetn = 0;
        #1;
        m_clear();
        ntot++; if (busy_vec !== 32'd0) $display("FAIL mid_busy got=%h exp=0", busy_vec); else npass++;
        ntot++; if (stall_cnt !== 32'd0) $display("FAIL mid_stall got=%0d exp=0", stall_cnt); else npass++;
        ntot++; if (sb_err !== 1'b0) $display("FAIL mid_err got=%b exp=0", sb_err); else npass++;
        ntot++; if (id_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", id_ready); else npass++;
        @(negedge clk);
        resetn = 1;
        idle();
        tick();
        ntot++; if (stall_cnt !== 32'd0) $display("FAIL mid_resume got=%0d exp=0", stall_cnt); else npass++;
    endtask

    task automatic test_raw();
        logic [31:0] s0;
        issue(5);
        #1;
        ntot++; if (issue_fire !== 1'b1) $display("FAIL raw_issue got=%b exp=1", issue_fire); else npass++;
        tick();
        ntot++; if (busy_vec !== 32'h20) $display("FAIL raw_busy got=%h exp=00000020", busy_vec); else npass++;
        s0 = stall_cnt;
        idle();
        id_valid = 1; id_src1 = 5; id_src1_used = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            ntot++; if (id_ready !== 1'b0) $display("FAIL raw_ready got=%b exp=0", id_ready); else npass++;
            tick();
            ntot++; if (stall_cnt !== s0 + 32'(k)) $display("FAIL raw_stall got=%0d exp=%0d", stall_cnt, s0 + 32'(k)); else npass++;
        end
        wb_valid = 1; wb_we = 1; wb_dest = 5;
        #1;
        ntot++; if (id_ready !== 1'b0) $display("FAIL raw_nobypass got=%b exp=0", id_ready); else npass++;
        tick();
        wb_valid = 0;
        #1;
        ntot++; if (id_ready !== 1'b1) $display("FAIL raw_release got=%b exp=1", id_ready); else npass++;
        ntot++; if (issue_fire !== 1'b1) $display("FAIL raw_fire got=%b exp=1", issue_fire); else npass++;
        tick();
    endtask

    task automatic test_same_cycle();
        issue(7); tick();
        issue(7);
        wb_valid = 1; wb_we = 1; wb_dest = 7;
        tick();
        idle();
        #1;
        ntot++; if (busy_vec[7] !== 1'b1) $display("FAIL same_busy got=%b exp=1", busy_vec[7]); else npass++;
        wb_valid = 1; wb_we = 1; wb_dest = 7;
        tick();
        idle();
        #1;
        ntot++; if (busy_vec[7] !== 1'b0) $display("FAIL same_cnt1 got=%b exp=0", busy_vec[7]); else npass++;
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            issue(9);
            #1;
            ntot++; if (issue_fire !== 1'b1) $display("FAIL waw_issue%0d got=%b exp=1", k, issue_fire); else npass++;
            tick();
        end
        issue(9);
        #1;
        ntot++; if (id_ready !== 1'b0) $display("FAIL waw_sat got=%b exp=0", id_ready); else npass++;
        tick();
        wb_valid = 1; wb_we = 1; wb_dest = 9;
        #1;
        ntot++; if (id_ready !== 1'b0) $display("FAIL waw_samecyc got=%b exp=0", id_ready); else npass++;
        tick();
        wb_valid = 0;
        #1;
        ntot++; if (issue_fire !== 1'b1) $display("FAIL waw_release got=%b exp=1", issue_fire); else npass++;
        tick();
        idle();
        wb_valid = 1; wb_we = 1; wb_dest = 9;
        repeat (3) tick();
        idle();
        #1;
        ntot++; if (busy_vec !== m_busy()) $display("FAIL waw_drain got=%h exp=%h", busy_vec, m_busy()); else npass++;
    endtask

    task automatic test_flush();
        issue(2); tick();
        issue(4); tick();
        issue(6); tick();
        ntot++; if (busy_vec[6:2] !== 5'b10101) $display("FAIL fl_pre got=%b exp=10101", busy_vec[6:2]); else npass++;
        issue(8);
        wb_valid = 1; wb_we = 1; wb_dest = 2;
        flush = 1;
        #1;
        ntot++; if (issue_fire !== 1'b0) $display("FAIL fl_fire got=%b exp=0", issue_fire); else npass++;
        tick();
        idle();
        #1;
        ntot++; if (busy_vec !== 32'd0) $display("FAIL fl_busy got=%h exp=0", busy_vec); else npass++;
        ntot++; if (sb_err !== merr) $display("FAIL fl_err got=%b exp=%b", sb_err, merr); else npass++;
    endtask

    task automatic test_random();
        int cands[$];
        bit ef;
        for (int n = 0; n < 400; n++) begin
            id_valid     = ($urandom % 4) != 0;
            id_src1      = 5'($urandom % 12);
            id_src2      = 5'($urandom % 12);
            id_src1_used = ($urandom % 3) == 0;
            id_src2_used = ($urandom % 4) == 0;
            id_dest      = 5'($urandom % 12);
            id_dest_we   = ($urandom % 4) != 0;
            ex_allowin   = ($urandom % 4) != 0;
            flush        = ($urandom % 40) == 0;
            cands.delete();
            for (int i = 1; i < 32; i++) if (mcnt[i] > 0) cands.push_back(i);
            wb_valid = ($urandom % 2) == 0;
            wb_we    = ($urandom % 5) != 0;
            wb_dest  = (cands.size() > 0) ? 5'(cands[$urandom % cands.size()]) : 5'd0;
            #1;
            ef = m_fire();
            ntot++; if (id_ready !== !m_hazard()) $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, id_ready, !m_hazard()); else npass++;
            ntot++; if (issue_fire !== ef) $display("FAIL rnd_fire n=%0d got=%b exp=%b", n, issue_fire, ef); else npass++;
            tick();
            ntot++; if (busy_vec !== m_busy()) $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy_vec, m_busy()); else npass++;
            ntot++; if (stall_cnt !== mstall) $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall_cnt, mstall); else npass++;
            ntot++; if (sb_err !== merr) $display("FAIL rnd_err n=%0d got=%b exp=%b", n, sb_err, merr); else npass++;
        end
        idle();
    endtask

    initial begin
        m_clear();
        test_reset();
        test_reg0_underflow();
        test_reset_mid();
        test_raw();
        test_same_cycle();
        test_waw();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
